// File: rtl/przesuniecie_pkg.sv
// ============================================================================
// przesuniecie_pkg : types and helpers shared by the sign-magnitude shifters
// Revision: 1.0
// ============================================================================
`default_nettype none

package przesuniecie_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BITS_DEFAULT = 8;

  // True for a sign-magnitude value of width 'bits' that is negative and not -0.
  function automatic logic is_neg_nonzero(input logic [31:0] value, input int bits);
    logic [31:0] sign_mask;
    logic [31:0] mag_mask;
    sign_mask = 32'h1 << (bits - 1);
    mag_mask  = sign_mask - 32'h1;
    return ((value & sign_mask) != 32'h0) && ((value & mag_mask) != 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/przesuniecie_krok.sv
// ============================================================================
// przesuniecie_krok : one-bit left shift of a magnitude with overflow flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module przesuniecie_krok #(
  parameter int W = 7
) (
  input  logic [W-1:0] mag_i,
  output logic [W-1:0] mag_o,
  output logic         ovf_o
);

  assign mag_o = {mag_i[W-2:0], 1'b0};
  assign ovf_o = mag_i[W-1];

endmodule

`default_nettype wire

// File: rtl/przesuniecie_lewo_seq.sv
// ============================================================================
// przesuniecie_lewo_seq : sequential sign-magnitude left shifter, 1 bit/clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module przesuniecie_lewo_seq
  import przesuniecie_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic            o_busy,
  output logic            o_valid,
  output logic [BITS-1:0] o_result,
  output logic            o_error
);

  localparam int MAG_W = BITS - 1;
  localparam int CNT_W = $clog2(BITS);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state_q;
  logic             a_sign_q;
  logic [MAG_W-1:0] mag_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic [MAG_W-1:0] b_mag;
  logic             b_err;
  logic [MAG_W-1:0] step_mag;
  logic             step_ovf;

  assign b_mag = i_arg_B[MAG_W-1:0];
  assign b_err = is_neg_nonzero(32'(i_arg_B), BITS) || (32'(b_mag) >= 32'(MAG_W));

  przesuniecie_krok #(
    .W (MAG_W)
  ) u_krok (
    .mag_i (mag_q),
    .mag_o (step_mag),
    .ovf_o (step_ovf)
  );

  // Every request passes through SHIFT at least once; a zero counter there
  // means "finish now", so errors and zero shifts take one extra cycle and an
  // overflow finishes on the cycle after it is seen.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      a_sign_q <= 1'b0;
      mag_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      o_busy   <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_error  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            a_sign_q <= i_arg_A[BITS-1];
            mag_q    <= i_arg_A[MAG_W-1:0];
            err_q    <= b_err;
            cnt_q    <= b_err ? '0 : b_mag[CNT_W-1:0];
            o_busy   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            o_valid  <= 1'b1;
            o_error  <= err_q;
            o_result <= err_q ? '0 : {a_sign_q, mag_q};
            state_q  <= DONE;
          end else if (step_ovf) begin
            err_q <= 1'b1;
            cnt_q <= '0;
          end else begin
            mag_q <= step_mag;
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        DONE: begin
          o_busy  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_przesuniecie_lewo_seq.sv
// ============================================================================
// tb_przesuniecie_lewo_seq : bench for the sequential left shifter (BITS=8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_przesuniecie_lewo_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] arg_a;
  logic [7:0] arg_b;
  logic       busy;
  logic       valid;
  logic [7:0] result;
  logic       error;

  int total_cnt = 0;
  int pass_cnt  = 0;

  przesuniecie_lewo_seq #(.BITS(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_arg_A  (arg_a),
    .i_arg_B  (arg_b),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result),
    .o_error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value*2^n on the magnitude, error if it leaves 7 bits.
  // lat = number of edges after the accept edge until o_valid is seen.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic err, output int lat);
    int amag, bmag, val;
    amag = int'(a[6:0]);
    bmag = int'(b[6:0]);
    err  = 1'b0;
    res  = 8'h00;
    lat  = 1;
    if ((b[7] && bmag != 0) || bmag >= 7) begin
      err = 1'b1;
    end else if (bmag == 0) begin
      res = a;
    end else begin
      val = amag;
      lat = bmag + 1;
      for (int j = 1; j <= bmag; j++) begin
        if (val * 2 > 127) begin
          err = 1'b1;
          lat = j + 1;
          break;
        end
        val = val * 2;
      end
      if (!err) res = {a[7], 7'(val)};
    end
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  // Issue one request and capture what the DUT returns; lat=-1 on timeout.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic err, output int lat,
                       output logic busy_acc, output logic valid_after);
    wait_idle();
    arg_a = a; arg_b = b; start = 1'b1;
    @(posedge clk); #1;
    busy_acc = busy;
    start = 1'b0;
    arg_a = 8'($urandom); arg_b = 8'($urandom);
    lat = -1; res = 8'hxx; err = 1'bx; valid_after = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      if (valid) begin
        lat = c - 1;
        res = result;
        err = error;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == -1 && valid) lat = 40;
    if (lat != -1) begin
      @(posedge clk); #1;
      valid_after = valid;
    end
  endtask

  task automatic test_reset();
    start = 1'b0; arg_a = 8'h00; arg_b = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, valid, result, error} !== 11'h000)
      $display("FAIL reset_outputs: got busy=%b valid=%b result=%h error=%b, want all 0",
               busy, valid, result, error);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_vectors(input string name, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] res, exp_res;
    logic err, exp_err, bacc, vafter;
    int lat, exp_lat;
    model(a, b, exp_res, exp_err, exp_lat);
    do_op(a, b, res, err, lat, bacc, vafter);
    total_cnt++;
    if (lat !== exp_lat || res !== exp_res || err !== exp_err || bacc !== 1'b1 || vafter !== 1'b0)
      $display("FAIL %s: A=%h B=%h got res=%h err=%b lat=%0d busy=%b vnext=%b, want res=%h err=%b lat=%0d busy=1 vnext=0",
               name, a, b, res, err, lat, bacc, vafter, exp_res, exp_err, exp_lat);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    test_vectors("plus3_shl2",   8'b0000_0011, 8'b0000_0010);
    test_vectors("minus5_shl3",  8'b1000_0101, 8'b0000_0011);
    test_vectors("overflow_64",  8'b0100_0000, 8'b0000_0001);
    test_vectors("neg_shift",    8'b0000_0111, 8'b1000_0010);
    test_vectors("negzero_b",    8'b1000_0000, 8'b1000_0000);
    test_vectors("shift_7",      8'b0000_0001, 8'b0000_0111);
    test_vectors("max_shift_6",  8'b1000_0001, 8'b0000_0110);
    test_vectors("late_ovf",     8'b0000_0101, 8'b0000_0110);
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = {1'($urandom), 7'($urandom_range(0, 8))};
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      test_vectors("random", a, b);
    end
  endtask

  task automatic test_busy_ignore();
    int vcount = 0, first_c = -1;
    logic [7:0] first_res = 8'hxx;
    wait_idle();
    arg_a = 8'h01; arg_b = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) begin start = 1'b1; arg_a = 8'h03; arg_b = 8'h01; end
      if (c == 2) start = 1'b0;
      if (valid) begin
        vcount++;
        if (first_c < 0) begin first_c = c - 1; first_res = result; end
      end
      @(posedge clk); #1;
    end
    total_cnt++;
    if (vcount !== 1 || first_c !== 6 || first_res !== 8'h20)
      $display("FAIL busy_ignore: got valids=%0d lat=%0d res=%h, want valids=1 lat=6 res=20",
               vcount, first_c, first_res);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] res;
    logic err, bacc, vafter;
    int lat, vcount = 0;
    wait_idle();
    arg_a = 8'h01; arg_b = 8'h06; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy, valid, result, error} !== 11'h000)
      $display("FAIL reset_abort_outputs: got busy=%b valid=%b result=%h error=%b, want all 0",
               busy, valid, result, error);
    else pass_cnt++;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (valid) vcount++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (vcount !== 0)
      $display("FAIL reset_abort_novalid: got %0d valid pulses, want 0", vcount);
    else pass_cnt++;
    do_op(8'h02, 8'h02, res, err, lat, bacc, vafter);
    total_cnt++;
    if (res !== 8'h08 || err !== 1'b0 || lat !== 3)
      $display("FAIL reset_abort_recover: got res=%h err=%b lat=%0d, want res=08 err=0 lat=3",
               res, err, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int vc[$];
    int bad_res = 0;
    wait_idle();
    arg_a = 8'h01; arg_b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 12; c++) begin
      if (valid) begin
        vc.push_back(c - 1);
        if (result !== 8'h04 || error !== 1'b0) bad_res++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total_cnt++;
    if (vc.size() < 2 || vc[0] !== 3 || vc[1] - vc[0] !== 5 || bad_res !== 0)
      $display("FAIL back_to_back: got %0d valids first=%0d gap=%0d badres=%0d, want first=3 gap=5 badres=0",
               vc.size(), (vc.size() > 0) ? vc[0] : -1,
               (vc.size() > 1) ? vc[1] - vc[0] : -1, bad_res);
    else pass_cnt++;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
